// File: rtl/conv1_window_ctrl_pkg.sv
// Shared geometry, widths and state encoding for the conv1 window
// sequencer and its line-ring pointers.
package conv1_pkg;

   localparam int WIDTH     = 28;
   localparam int HEIGHT    = 28;
   localparam int KSIZE     = 5;
   localparam int DW        = 8;

   localparam int OUT_DIM   = WIDTH - KSIZE + 1;
   localparam int BUF_DEPTH = WIDTH * KSIZE;

   localparam int ADDR_W    = $clog2(BUF_DEPTH);
   localparam int LINE_W    = $clog2(KSIZE);
   localparam int COL_W     = $clog2(WIDTH);
   localparam int ROW_W     = $clog2(OUT_DIM);

   localparam logic [COL_W-1:0] LAST_WCOL = COL_W'(WIDTH - 1);
   localparam logic [COL_W-1:0] LAST_RCOL = COL_W'(WIDTH - KSIZE);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - KSIZE);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CALC,
      LOAD,
      DONE
   } state_e;

   function automatic logic [ADDR_W-1:0] buf_addr(
      input logic [LINE_W-1:0] line,
      input logic [COL_W-1:0]  col
   );
      return ADDR_W'(line) * ADDR_W'(WIDTH) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/conv1_window_ctrl_if.sv
// AXI-stream style pixel channel between the DMA source and the
// conv1 window controller.
interface conv1_axis_if;

   logic [conv1_pkg::DW-1:0] data;
   logic                     valid;
   logic                     ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/conv1_window_ctrl_ring_line_ptr.sv
// Mod-N line pointer into the line-buffer ring, with synchronous
// clear and single-step increment.
module ring_line_ptr #(
   parameter int N = 5,
   localparam int W = $clog2(N)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/conv1_window_ctrl.sv
// conv1 5x5 line-buffer sequencer: fills KSIZE lines, then alternates
// one row of window reads with one line refill. Perf counters: CONV1_CTRL_PERF_EN.
module conv1_window_ctrl
   import conv1_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   conv1_axis_if.slave       s_axis,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DW-1:0]     o_wr_data,
   output logic [LINE_W-1:0] o_rd_line,
   output logic [COL_W-1:0]  o_rd_col,
   output logic              o_win_valid,
   output logic [ROW_W-1:0]  o_win_row,
   input  logic              i_stall
`ifdef CONV1_CTRL_PERF_EN
   ,
   output logic [15:0]       o_stall_cnt,
   output logic [15:0]       o_frame_cycles
`endif
);

   state_e              state_q;
   logic [COL_W-1:0]    wr_col_q;
   logic [COL_W-1:0]    rd_col_q;
   logic [ROW_W-1:0]    win_row_q;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;
   logic                win_valid_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DW-1:0]       wr_data_q;
   logic [LINE_W-1:0]   wr_line;
   logic [LINE_W-1:0]   rd_line;
   logic                start_go;
   logic                accept;
   logic                line_end;

   assign start_go = (state_q == IDLE) && i_start;
   assign accept   = ready_q && s_axis.valid;
   assign line_end = accept && (wr_col_q == LAST_WCOL);

   // The fill pass wraps wr_line 4->0 on its own, landing on rd_line.
   ring_line_ptr #(.N(KSIZE)) u_wr_line (
      .clk_i  (i_clk),
      .rst_ni (i_rst),
      .clr_i  (start_go),
      .inc_i  (line_end),
      .ptr_o  (wr_line)
   );

   ring_line_ptr #(.N(KSIZE)) u_rd_line (
      .clk_i  (i_clk),
      .rst_ni (i_rst),
      .clr_i  (start_go),
      .inc_i  (line_end && (state_q == LOAD)),
      .ptr_o  (rd_line)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         wr_col_q    <= '0;
         rd_col_q    <= '0;
         win_row_q   <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         win_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         wr_en_q <= accept;
         done_q  <= 1'b0;
         if (accept) begin
            wr_addr_q <= buf_addr(wr_line, wr_col_q);
            wr_data_q <= s_axis.data;
            wr_col_q  <= line_end ? '0 : wr_col_q + COL_W'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  state_q     <= FILL;
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  wr_col_q    <= '0;
                  rd_col_q    <= '0;
                  win_row_q   <= '0;
                  win_valid_q <= 1'b0;
               end
            end
            FILL: begin
               if (line_end && (wr_line == LINE_W'(KSIZE - 1))) begin
                  state_q <= CALC;
                  ready_q <= 1'b0;
               end
            end
            CALC: begin
               // A shown valid window is consumed; the column then advances.
               if (win_valid_q && (rd_col_q == LAST_RCOL)) begin
                  win_valid_q <= 1'b0;
                  rd_col_q    <= '0;
                  if (win_row_q == LAST_ROW) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= LOAD;
                     ready_q <= 1'b1;
                  end
               end else begin
                  win_valid_q <= !i_stall;
                  if (win_valid_q) begin
                     rd_col_q <= rd_col_q + COL_W'(1);
                  end
               end
            end
            LOAD: begin
               if (line_end) begin
                  state_q   <= CALC;
                  ready_q   <= 1'b0;
                  win_row_q <= win_row_q + ROW_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_axis.ready = ready_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_rd_line    = rd_line;
   assign o_rd_col     = rd_col_q;
   assign o_win_valid  = win_valid_q;
   assign o_win_row    = win_row_q;

`ifdef CONV1_CTRL_PERF_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] frame_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         stall_cnt_q <= '0;
         frame_cnt_q <= '0;
      end else if (start_go) begin
         stall_cnt_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         if ((state_q == CALC) && i_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if ((state_q != IDLE) && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign o_stall_cnt    = stall_cnt_q;
   assign o_frame_cycles = frame_cnt_q;
`endif

endmodule

// File: doc/conv1_window_ctrl.md
Name: conv1_window_ctrl

Overview:
Sequencing controller for the conv1 5x5 line buffer (5 lines x WIDTH bytes, ring-organised).
- Accepts the 28x28 8-bit image from an AXI-stream slave with real backpressure.
- Issues buffer write addresses and window-read coordinates: oldest line index and column.
- Interleaves one row of window reads with one row of refill, and signals frame completion to the layer scheduler.
- Sits between the DMA/AXI source and the line-buffer/window-register datapath feeding the conv1 PE array.

Parameters:
WIDTH, 28, image columns
HEIGHT, 28, image rows
KSIZE, 5, kernel size = number of buffered lines
DW, 8, pixel width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse; ignored unless IDLE
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at frame end
s_axis_data  in  DW  pixel
s_axis_valid  in  1  pixel valid
s_axis_ready  out  1  controller accepts pixel
o_wr_en  out  1  line-buffer write strobe
o_wr_addr  out  8  wr_line*WIDTH+wr_col, 0..139
o_wr_data  out  DW  registered s_axis_data
o_rd_line  out  3  ring index of top window row, 0..KSIZE-1
o_rd_col  out  5  window left column, 0..WIDTH-KSIZE (23)
o_win_valid  out  1  o_rd_line/o_rd_col describe a window to read this cycle
o_win_row  out  5  output row of the current window, 0..HEIGHT-KSIZE
i_stall  in  1  downstream not ready; freezes window issue

Behaviour:
- Reset: async on i_rst low.
  - All outputs 0, state IDLE, all counters 0.
  - Reset mid-frame aborts the frame; no o_done is produced.
- Handshake: a beat is accepted when s_axis_valid && s_axis_ready.
  - On acceptance, o_wr_en/o_wr_addr/o_wr_data are registered and asserted the next cycle, so write latency = 1.
  - If s_axis_valid is low, the controller holds and the counters freeze.
- States:
  - IDLE:
    - s_axis_ready=0.
    - On i_start: go to FILL; clear wr_line, wr_col, rd_line, rd_col and o_win_row.
  - FILL:
    - s_axis_ready=1.
    - Each beat increments wr_col. At WIDTH-1, wr_col wraps to 0 and wr_line increments.
    - After KSIZE*WIDTH=140 beats: go to CALC with wr_line=0, rd_line=0.
  - CALC:
    - s_axis_ready=0.
    - Each cycle with i_stall=0: o_win_valid=1, then rd_col increments.
    - Cycle with i_stall=1: o_win_valid=0, rd_col held.
    - After issuing rd_col=23: rd_col returns to 0. If o_win_row==HEIGHT-KSIZE go to DONE, else go to LOAD.
  - LOAD:
    - s_axis_ready=1.
    - Accept WIDTH beats into line wr_line, which equals rd_line (the oldest line). i_stall is ignored.
    - On the last beat: rd_line and wr_line advance mod KSIZE (4 wraps to 0), o_win_row increments, go to CALC.
  - DONE:
    - o_done=1 for one cycle, o_busy=0 the next cycle, go to IDLE.
- Registered outputs: o_win_valid, o_rd_line, o_rd_col and o_win_row are registered and mutually consistent in the same cycle.
- Totals per frame: 784 accepted beats, 576 window-valid cycles, 24 CALC phases, 23 LOAD phases.
- i_start while busy has no effect.
- Extra stream beats arriving in CALC/DONE/IDLE are not accepted (ready=0).
- Line ring ordering: window row r uses buffer lines (rd_line+k)%KSIZE for k=0..4.

Optional Feature:
CONV1_CTRL_PERF_EN
- Defined: adds o_stall_cnt (16 bit) and o_frame_cycles (16 bit).
  - o_stall_cnt counts CALC cycles with i_stall=1.
  - o_frame_cycles counts every cycle from leaving IDLE to DONE.
  - Both clear on i_start and hold their value after o_done until the next start.
  - Both saturate at 0xFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package conv1_pkg:
  - WIDTH, HEIGHT, KSIZE, DW.
  - Derived OUT_DIM=WIDTH-KSIZE+1 and BUF_DEPTH=WIDTH*KSIZE.
  - Address widths and the state typedef {IDLE, FILL, CALC, LOAD, DONE}.
- One natural sub-module, ring_line_ptr: a mod-KSIZE pointer with increment/clear, instanced for rd_line and wr_line.

Test Plan:
- Reset then i_start, 140 back-to-back beats (values 0..139) -> o_wr_addr 0..139 each one cycle after its beat; s_axis_ready drops exactly after beat 139; first o_win_valid with rd_line=0, rd_col=0, win_row=0.
- Full frame with s_axis_valid always high, i_stall=0 -> 576 o_win_valid cycles; first LOAD writes addr 0..27; second LOAD writes 28..55; rd_line sequence 0,1,2,3,4,0,...; single o_done; o_busy low afterwards.
- i_stall high for 3 cycles at rd_col=10 in row 5 -> rd_col holds at 10, o_win_valid=0 for 3 cycles, resumes at 10; window total still 576.
- Random s_axis_valid gaps (~50% duty) -> write address sequence identical to gap-free run; no writes while valid low.
- i_rst asserted mid-LOAD in row 12 -> all outputs 0 immediately (asynchronously); no o_done; a following i_start runs a clean full frame.
- i_start pulsed during CALC -> ignored, counters undisturbed; with CONV1_CTRL_PERF_EN, a 7-cycle stall gives o_stall_cnt=7.
